pong_match_ctrl: RTL

- Match sequencer for the Pong game; owns the paddle/ball object reset and the ball-motion enable.
- Tracks both scores, runs the serve countdown, and detects game over.
- Sits between top-level input (start button) and the paddle instances (drives their `rst`) plus the ball block (drives `objs_rst` and `play_en`).
- Consumes miss strobes from the ball/collision logic.

---
 rtl/pong_match_ctrl_pkg.sv | 22 ++
 rtl/pong_serve_timer.sv | 33 +++
 rtl/pong_match_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_pkg.sv
// rtl/pong_match_ctrl_pkg.sv - shared encodings and constants for the pong match sequencer
//   state_e      : match state encodings (ST_IDLE..ST_PAUSED), also driven on the debug/HUD port
//   WIN_*        : winner codes driven on the winner port
//   PADDLE_Y_MAX : screen constant used by the sibling paddle blocks
package pong_match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4,
    ST_PAUSED    = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_LEFT  = 2'd1;
  localparam logic [1:0] WIN_RIGHT = 2'd2;

  localparam int PADDLE_Y_MAX = 280;

endpackage

// File: rtl/pong_serve_timer.sv
// rtl/pong_serve_timer.sv - loadable down-counter timing the serve countdown
//   game_clk : clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over en)
//   en       : decrement by one per cycle, holding at zero
//   load_val : value loaded on load
//   done     : count is zero
module pong_serve_timer #(
  parameter int W = 7
) (
  input  logic         game_clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge game_clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: serve countdown, scoring, game over
//   Optional feature macro: PONG_PAUSE_EN (adds the pause port and the PAUSED state)
//   game_clk    : game tick clock
//   rst         : synchronous active-high reset
//   start       : level, begins a match from IDLE or GAME_OVER
//   miss_left   : ball passed left edge, right player scores
//   miss_right  : ball passed right edge, left player scores
//   pause       : pause toggle strobe (PONG_PAUSE_EN only)
//   objs_rst    : registered reset to paddles and ball
//   play_en     : registered ball motion enable
//   score_left  : left score
//   score_right : right score
//   winner      : 0 none, 1 left, 2 right
//   state       : current state encoding
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 120,
  parameter int SCORE_W     = 4
) (
  input  logic               game_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
`ifdef PONG_PAUSE_EN
  input  logic               pause,
`endif
  output logic               objs_rst,
  output logic               play_en,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic [1:0]         winner_q, winner_d;
  logic               objs_rst_q, objs_rst_d;
  logic               play_en_q, play_en_d;
  logic               timer_load;
  logic               timer_done;

  // Loading on every entry to SERVE and counting down to zero gives a
  // dwell of exactly SERVE_TICKS cycles in SERVE.
  pong_serve_timer #(
    .W(CNT_W)
  ) u_serve_timer (
    .game_clk(game_clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (state_q == ST_SERVE),
    .load_val(SERVE_LOAD),
    .done    (timer_done)
  );

  // State and match data registers
  always_ff @(posedge game_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      score_left_q  <= '0;
      score_right_q <= '0;
      winner_q      <= WIN_NONE;
      objs_rst_q    <= 1'b1;
      play_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      objs_rst_q    <= objs_rst_d;
      play_en_q     <= play_en_d;
    end
  end

  // Next-state and score logic
  always_comb begin
    state_d       = state_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    timer_load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_d       = ST_SERVE;
          score_left_d  = '0;
          score_right_d = '0;
          winner_d      = WIN_NONE;
          timer_load    = 1'b1;
        end
      end
      ST_SERVE: begin
        if (timer_done) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // A double miss is a re-serve with no score; a miss beats a pause.
        if (miss_left && miss_right) begin
          state_d = ST_POINT;
        end else if (miss_left) begin
          score_right_d = score_right_q + 1'b1;
          state_d       = ST_POINT;
        end else if (miss_right) begin
          score_left_d = score_left_q + 1'b1;
          state_d      = ST_POINT;
`ifdef PONG_PAUSE_EN
        end else if (pause) begin
          state_d = ST_PAUSED;
`endif
        end
      end
      ST_POINT: begin
        if (score_left_q == WIN_S) begin
          state_d  = ST_GAME_OVER;
          winner_d = WIN_LEFT;
        end else if (score_right_q == WIN_S) begin
          state_d  = ST_GAME_OVER;
          winner_d = WIN_RIGHT;
        end else begin
          state_d    = ST_SERVE;
          timer_load = 1'b1;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSED: begin
        if (pause) begin
          state_d = ST_PLAY;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // with state on the same edge. objs_rst pulses only on SERVE entry so the
  // paddles can move during the rest of the countdown.
  always_comb begin
    objs_rst_d = (state_d == ST_IDLE) ||
                 ((state_d == ST_SERVE) && (state_q != ST_SERVE));
    play_en_d  = (state_d == ST_PLAY);
  end

  assign objs_rst    = objs_rst_q;
  assign play_en     = play_en_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule
